// File: rtl/uart_rx_pkg.sv
// Shared types, state encodings and helpers for the oversampled UART receiver.
package uart_rx_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t StIdle   = 3'd0;
  localparam rx_state_t StStart  = 3'd1;
  localparam rx_state_t StData   = 3'd2;
  localparam rx_state_t StParity = 3'd3;
  localparam rx_state_t StStop   = 3'd4;

  localparam logic [1:0] DataBits5 = 2'b00;
  localparam logic [1:0] DataBits6 = 2'b01;
  localparam logic [1:0] DataBits7 = 2'b10;
  localparam logic [1:0] DataBits8 = 2'b11;

  function automatic logic [3:0] data_bits_count(input logic [1:0] enc);
    case (enc)
      DataBits5: return 4'd5;
      DataBits6: return 4'd6;
      DataBits7: return 4'd7;
      default:   return 4'd8;
    endcase
  endfunction

  // acc is the running XOR of the received data bits.
  function automatic logic parity_error(input logic acc, input logic sample, input logic odd);
    return (acc ^ sample) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
interface uart_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with a configurable reset value.
module uart_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: start validation, mid-bit sampling, valid/ready word delivery.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OSR    = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       osr_tick_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop2_i,
  uart_rx_if.master  rx_if
);
  localparam int unsigned TickW   = $clog2(OSR);
  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam logic [TickW-1:0] TickMid  = TickW'(OSR / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OSR - 1);

  logic rx_s;

  uart_sync #(.ResetVal(1'b1)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  rx_state_t           state_q, state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BitCntW-1:0]  nbits_q, nbits_d;
  logic                par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_acc_q, par_acc_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                done;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    shreg_d    = shreg_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;

    if (!en_i) begin
      state_d = StIdle;
    end else if (osr_tick_i) begin
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d    = StStart;
            tick_cnt_d = '0;
            nbits_d    = BitCntW'(data_bits_count(data_bits_i));
            par_en_d   = parity_en_i;
            par_odd_d  = parity_odd_i;
            stop2_d    = stop2_i;
          end
        end
        StStart: begin
          if (tick_cnt_q == TickMid) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = StData;
              bit_cnt_d = '0;
              shreg_d   = '0;
              par_acc_d = 1'b0;
              perr_d    = 1'b0;
              ferr_d    = 1'b0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_q | (DATA_W'(rx_s) << bit_cnt_q);
            par_acc_d  = par_acc_q ^ rx_s;
            if (bit_cnt_q == nbits_q - BitCntW'(1)) begin
              bit_cnt_d = '0;
              state_d   = par_en_q ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
            perr_d     = parity_error(par_acc_q, rx_s, par_odd_q);
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
            ferr_d     = ferr_q | ~rx_s;
            if (stop2_q && bit_cnt_q == '0) begin
              bit_cnt_d = BitCntW'(1);
            end else begin
              // Leave at mid-stop so a back-to-back start edge is not missed.
              state_d = StIdle;
              done    = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (done) begin
      if (rx_valid_q && !rx_if.rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_valid_d   = 1'b1;
        rx_data_d    = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      nbits_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      shreg_q      <= '0;
      par_acc_q    <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      nbits_q      <= nbits_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop2_q      <= stop2_d;
      shreg_q      <= shreg_d;
      par_acc_q    <= par_acc_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.overrun    = overrun_q;
endmodule
